if_fetch_unit: RTL and testbench

- Instruction-fetch stage: the producer side of the IF/ID pipeline register.
- Owns the PC and issues requests to instruction memory over a request/grant/response handshake with variable latency.
- Buffers returned words in a small prefetch FIFO and presents {PC+4, instruction, valid, history index} to IF/ID.
- Honours stall from the hazard unit and redirect from branch/jump resolution, discarding wrong-path responses.

---
 rtl/if_pkg.sv | 20 ++
 rtl/if_prefetch_fifo.sv | 54 +++++
 rtl/if_fetch_unit.sv | 155 +++++++++++++++
 tb/tb_if_fetch_unit.sv | 370 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/if_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Holds the fetch FSM states, FIFO entry layout and history-index slice.
package if_pkg;

   typedef enum logic [1:0] {
      BOOT,
      RUN,
      FLUSH
   } fetch_state_t;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } fifo_entry_t;

   localparam logic [31:0] NOP_INSTR = 32'h0;
   localparam int BHI_LSB = 2;
   localparam int BHI_W = 7;

endpackage

// File: rtl/if_prefetch_fifo.sv
// Small synchronous FIFO with clear; head is read combinationally.
// Serves as the instruction prefetch buffer and as the issued-PC queue.
module if_prefetch_fifo
   import if_pkg::*;
#(
   parameter int DEPTH = 2,
   parameter int W = 64
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push,
   input  logic [W-1:0]           push_data,
   input  logic                   pop,
   input  logic                   clear,
   output logic [$clog2(DEPTH):0] count,
   output logic [W-1:0]           head
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] rd_ptr;
   logic [AW-1:0] wr_ptr;
   logic          do_push;
   logic          do_pop;

   assign do_pop  = pop && (count != '0);
   assign do_push = push && ((count != FULL_CNT) || do_pop);
   assign head    = mem[rd_ptr];

   // Pointer and occupancy bookkeeping; clear empties in one cycle.
   always_ff @(posedge clk) begin
      if (!rst || clear) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop) rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Entry storage; contents are meaningless while empty.
   always_ff @(posedge clk) begin
      if (rst && !clear && do_push) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, talks to imem, feeds IF/ID.
// Define IF_PERF_CNT_EN to add the perf_fetched/perf_discarded counters.
module if_fetch_unit
   import if_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int FIFO_DEPTH = 2,
   parameter int MAX_OUTSTANDING = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             stall,
   input  logic             redirect_valid,
   input  logic [31:0]      redirect_pc,
   output logic             imem_req,
   output logic [31:0]      imem_addr,
   input  logic             imem_gnt,
   input  logic             imem_rvalid,
   input  logic [31:0]      imem_rdata,
`ifdef IF_PERF_CNT_EN
   output logic [31:0]      perf_fetched,
   output logic [31:0]      perf_discarded,
`endif
   output logic [31:0]      out_pc4,
   output logic [31:0]      out_instr,
   output logic             out_valid,
   output logic [BHI_W-1:0] out_bhi
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   localparam logic [CW-1:0] MAX_OS = CW'(MAX_OUTSTANDING);
   localparam logic [CW:0] DEPTH_C = (CW+1)'(FIFO_DEPTH);

   fetch_state_t  state;
   fetch_state_t  state_nx;
   logic [31:0]   fetch_pc;
   logic [CW-1:0] inflight;
   logic [CW-1:0] discard;
   logic [CW-1:0] discard_nx;
   logic [CW-1:0] rvalid_ext;
   logic [CW-1:0] fifo_count;
   logic [CW-1:0] pcq_count;
   logic [CW:0]   reserved;
   logic [31:0]   pcq_head;
   fifo_entry_t   head_e;
   fifo_entry_t   push_e;
   logic          issue;
   logic          accept;
   logic          drop;
   logic          pop;

   assign rvalid_ext = {{(CW-1){1'b0}}, imem_rvalid};
   assign reserved   = {1'b0, fifo_count} + {1'b0, inflight};

   assign imem_req = (state == RUN) && !redirect_valid
                  && (inflight < MAX_OS)
                  && (reserved < DEPTH_C);
   assign imem_addr = fetch_pc;
   assign issue     = imem_req && imem_gnt;

   assign accept = imem_rvalid && !redirect_valid
                && (discard == '0) && (pcq_count != '0);
   assign drop   = imem_rvalid && !accept;
   assign push_e = '{pc: pcq_head, instr: imem_rdata};

   assign out_valid = (fifo_count != '0) && !redirect_valid;
   assign out_instr = out_valid ? head_e.instr : NOP_INSTR;
   assign out_pc4   = out_valid ? head_e.pc + 32'd4 : 32'd0;
   assign out_bhi   = out_valid ? head_e.pc[BHI_LSB +: BHI_W] : '0;
   assign pop       = out_valid && !stall;

   if_prefetch_fifo #(
      .DEPTH(FIFO_DEPTH),
      .W($bits(fifo_entry_t))
   ) u_ifq (
      .clk(clk),
      .rst(rst),
      .push(accept),
      .push_data(push_e),
      .pop(pop),
      .clear(redirect_valid),
      .count(fifo_count),
      .head(head_e)
   );

   if_prefetch_fifo #(
      .DEPTH(FIFO_DEPTH),
      .W(32)
   ) u_pcq (
      .clk(clk),
      .rst(rst),
      .push(issue),
      .push_data(fetch_pc),
      .pop(accept),
      .clear(redirect_valid),
      .count(pcq_count),
      .head(pcq_head)
   );

   // Next state and wrong-path discard count.
   always_comb begin
      state_nx   = state;
      discard_nx = discard;
      if (redirect_valid) begin
         discard_nx = inflight - rvalid_ext;
         state_nx   = (discard_nx != '0) ? FLUSH : RUN;
      end else begin
         unique case (state)
            BOOT: state_nx = RUN;
            RUN:  state_nx = RUN;
            FLUSH: begin
               if (imem_rvalid && (discard != '0))
                  discard_nx = discard - 1'b1;
               if (discard_nx == '0) state_nx = RUN;
            end
            default: state_nx = BOOT;
         endcase
      end
   end

   // State, fetch PC and outstanding-request tracking.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state    <= BOOT;
         fetch_pc <= RESET_PC;
         inflight <= '0;
         discard  <= '0;
      end else begin
         state   <= state_nx;
         discard <= discard_nx;
         if (redirect_valid) fetch_pc <= redirect_pc;
         else if (issue) fetch_pc <= fetch_pc + 32'd4;
         case ({issue, imem_rvalid})
            2'b10:   inflight <= inflight + 1'b1;
            2'b01:   inflight <= inflight - 1'b1;
            default: inflight <= inflight;
         endcase
      end
   end

`ifdef IF_PERF_CNT_EN
   // Count delivered instructions and every word thrown away.
   always_ff @(posedge clk) begin
      if (!rst) begin
         perf_fetched   <= '0;
         perf_discarded <= '0;
      end else begin
         if (pop) perf_fetched <= perf_fetched + 32'd1;
         perf_discarded <= perf_discarded + {31'd0, drop}
                         + (redirect_valid ? 32'(fifo_count) : 32'd0);
      end
   end
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Testbench for if_fetch_unit: queue-based reference model, random memory.
// Directed scenarios pin hand-computed values; a random phase follows.
module tb_if_fetch_unit;

   localparam logic [31:0] RPC = 32'h0000_0000;
   localparam int DEPTH = 2;
   localparam int MAXO = 2;

   logic        clk;
   logic        rst;
   logic        stall;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic [31:0] out_pc4;
   logic [31:0] out_instr;
   logic        out_valid;
   logic [6:0]  out_bhi;
`ifdef IF_PERF_CNT_EN
   logic [31:0] perf_fetched;
   logic [31:0] perf_discarded;
`endif

   if_fetch_unit #(
      .RESET_PC(RPC),
      .FIFO_DEPTH(DEPTH),
      .MAX_OUTSTANDING(MAXO)
   ) dut (
      .clk(clk),
      .rst(rst),
      .stall(stall),
      .redirect_valid(redirect_valid),
      .redirect_pc(redirect_pc),
      .imem_req(imem_req),
      .imem_addr(imem_addr),
      .imem_gnt(imem_gnt),
      .imem_rvalid(imem_rvalid),
      .imem_rdata(imem_rdata),
`ifdef IF_PERF_CNT_EN
      .perf_fetched(perf_fetched),
      .perf_discarded(perf_discarded),
`endif
      .out_pc4(out_pc4),
      .out_instr(out_instr),
      .out_valid(out_valid),
      .out_bhi(out_bhi)
   );

   typedef struct {
      logic [31:0] addr;
      int          ready;
      bit          wrong;
   } req_t;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
   } ent_t;

   req_t        mq[$];
   ent_t        fq[$];
   logic [31:0] m_pc;
   bit          m_boot;
   int unsigned pf;
   int unsigned pd;
   int          cyc;
   int          errors;
   int          checks;

   bit          rst_i;
   bit          stall_i;
   bit          redir_i;
   logic [31:0] rpc_i;
   int          gnt_pct;
   int          rsp_pct;
   int          lat_max;

   logic        s_req;
   logic [31:0] s_addr;
   logic        s_valid;
   logic [31:0] s_instr;
   logic [31:0] s_pc4;
   logic [6:0]  s_bhi;
`ifdef IF_PERF_CNT_EN
   logic [31:0] s_pd;
`endif

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] word_of(logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
   endfunction

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cyc=%0d actual=%h required=%h",
                  nm, cyc, act, exp);
      end
   endtask

   // One clock: drive, sample, compare against the model, advance it.
   task automatic step();
      int          wc;
      bit          e_req;
      bit          e_val;
      bit          rsp;
      logic [31:0] e_instr;
      logic [31:0] e_pc4;
      logic [6:0]  e_bhi;
      logic [31:0] hpc;
      req_t        r;
      @(negedge clk);
      rst            = rst_i;
      stall          = stall_i;
      redirect_valid = redir_i;
      redirect_pc    = rpc_i;
      imem_gnt = rst_i && ($urandom_range(99) < gnt_pct);
      rsp = rst_i && (mq.size() > 0) && (mq[0].ready <= cyc)
         && ($urandom_range(99) < rsp_pct);
      imem_rvalid = rsp;
      imem_rdata  = rsp ? word_of(mq[0].addr) : $urandom();
      #1;
      s_req   = imem_req;
      s_addr  = imem_addr;
      s_valid = out_valid;
      s_instr = out_instr;
      s_pc4   = out_pc4;
      s_bhi   = out_bhi;
`ifdef IF_PERF_CNT_EN
      s_pd    = perf_discarded;
`endif
      wc = 0;
      foreach (mq[i]) if (mq[i].wrong) wc++;
      e_req = m_boot && (wc == 0) && !redir_i && (mq.size() < MAXO)
           && (fq.size() + mq.size() < DEPTH);
      e_val   = (fq.size() > 0) && !redir_i;
      hpc     = e_val ? fq[0].pc : 32'd0;
      e_instr = e_val ? fq[0].instr : 32'd0;
      e_pc4   = e_val ? hpc + 32'd4 : 32'd0;
      e_bhi   = e_val ? hpc[8:2] : 7'd0;
      if (rst_i) begin
         chk("imem_req", {31'd0, s_req}, {31'd0, e_req});
         if (e_req) chk("imem_addr", s_addr, m_pc);
         chk("out_valid", {31'd0, s_valid}, {31'd0, e_val});
         chk("out_instr", s_instr, e_instr);
         chk("out_pc4", s_pc4, e_pc4);
         chk("out_bhi", {25'd0, s_bhi}, {25'd0, e_bhi});
`ifdef IF_PERF_CNT_EN
         chk("perf_fetched", perf_fetched, pf);
         chk("perf_discarded", perf_discarded, pd);
`endif
      end
      if (!rst_i) begin
         fq.delete();
         mq.delete();
         m_pc   = RPC;
         m_boot = 0;
         pf     = 0;
         pd     = 0;
      end else begin
         if (e_val && !stall_i) begin
            void'(fq.pop_front());
            pf++;
         end
         if (rsp) begin
            r = mq.pop_front();
            if (redir_i || r.wrong) pd++;
            else fq.push_back('{r.addr, word_of(r.addr)});
         end
         if (redir_i) begin
            pd += fq.size();
            fq.delete();
            foreach (mq[i]) mq[i].wrong = 1;
            m_pc = rpc_i;
         end
         if (e_req && imem_gnt) begin
            mq.push_back('{m_pc, cyc + int'($urandom_range(lat_max, 1)), 0});
            m_pc = m_pc + 32'd4;
         end
         m_boot = 1;
      end
      cyc++;
   endtask

   task automatic do_reset();
      rst_i   = 0;
      redir_i = 0;
      step();
      step();
      rst_i = 1;
   endtask

   task automatic fast_mem();
      gnt_pct = 100;
      rsp_pct = 100;
      lat_max = 1;
   endtask

   initial begin
      int n;
      errors = 0;
      checks = 0;
      cyc = 0;
      rst = 1'b0;
      stall = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc = '0;
      imem_gnt = 1'b0;
      imem_rvalid = 1'b0;
      imem_rdata = '0;
      m_pc = RPC;
      m_boot = 0;
      pf = 0;
      pd = 0;
      rst_i = 0;
      stall_i = 0;
      redir_i = 0;
      rpc_i = '0;
      fast_mem();

      // Zero-latency streaming from reset.
      do_reset();
      step();
      chk("boot_req", {31'd0, s_req}, 32'd0);
      chk("boot_valid", {31'd0, s_valid}, 32'd0);
      chk("boot_pc4", s_pc4, 32'd0);
      chk("boot_addr", s_addr, RPC);
      step();
      chk("c1_req", {31'd0, s_req}, 32'd1);
      chk("c1_addr", s_addr, 32'h0);
      step();
      chk("c2_addr", s_addr, 32'h4);
      step();
      chk("c3_valid", {31'd0, s_valid}, 32'd1);
      chk("c3_pc4", s_pc4, 32'h4);
      chk("c3_instr", s_instr, word_of(32'h0));
      step();
      chk("c4_pc4", s_pc4, 32'h8);
      chk("c4_addr", s_addr, 32'h8);

      // Stall with a full FIFO, then release.
      stall_i = 1;
      repeat (2) step();
      repeat (5) begin
         step();
         chk("stall_req", {31'd0, s_req}, 32'd0);
         chk("stall_pc4", s_pc4, 32'hC);
      end
      stall_i = 0;
      step();
      chk("rel_pc4_a", s_pc4, 32'hC);
      step();
      chk("rel_pc4_b", s_pc4, 32'h10);

      // Two in flight at 0x10/0x14, then redirect to 0x200.
      do_reset();
      stall_i = 1;
      repeat (8) step();
      rsp_pct = 0;
      redir_i = 1;
      rpc_i = 32'h10;
      step();
      redir_i = 0;
      step();
      chk("if_req_10", {31'd0, s_req}, 32'd1);
      chk("if_addr_10", s_addr, 32'h10);
      step();
      chk("if_addr_14", s_addr, 32'h14);
      step();
      chk("if_full_req", {31'd0, s_req}, 32'd0);
      redir_i = 1;
      rpc_i = 32'h200;
      step();
      chk("redir_valid", {31'd0, s_valid}, 32'd0);
      redir_i = 0;
      rsp_pct = 100;
      stall_i = 0;
      step();
      chk("flush_req_a", {31'd0, s_req}, 32'd0);
      step();
      chk("flush_req_b", {31'd0, s_req}, 32'd0);
      step();
      chk("resume_addr", s_addr, 32'h200);
      n = 0;
      do begin
         step();
         n++;
      end while (!s_valid && n < 10);
      chk("redir_pc4", s_pc4, 32'h204);

      // Redirect coinciding with a response while stalled.
      do_reset();
      stall_i = 1;
      rsp_pct = 0;
      repeat (3) step();
      rsp_pct = 100;
      redir_i = 1;
      rpc_i = 32'h300;
      step();
      chk("rr_valid", {31'd0, s_valid}, 32'd0);
      redir_i = 0;
      step();
      chk("rr_flush_req", {31'd0, s_req}, 32'd0);
`ifdef IF_PERF_CNT_EN
      chk("rr_perf_a", s_pd, 32'd1);
`endif
      step();
      chk("rr_req", {31'd0, s_req}, 32'd1);
      chk("rr_addr", s_addr, 32'h300);
`ifdef IF_PERF_CNT_EN
      chk("rr_perf_b", s_pd, 32'd2);
`endif

      // Redirect to the top word: PC+4 and fetch address wrap.
      do_reset();
      stall_i = 0;
      step();
      redir_i = 1;
      rpc_i = 32'hFFFF_FFFC;
      step();
      redir_i = 0;
      step();
      chk("wrap_addr_a", s_addr, 32'hFFFF_FFFC);
      step();
      chk("wrap_addr_b", s_addr, 32'h0);
      step();
      chk("wrap_valid", {31'd0, s_valid}, 32'd1);
      chk("wrap_pc4", s_pc4, 32'h0);
      chk("wrap_bhi", {25'd0, s_bhi}, 32'h7F);

      // Reset in the middle of a run with data buffered.
      stall_i = 1;
      step();
      rst_i = 0;
      step();
      rst_i = 1;
      stall_i = 0;
      step();
      chk("mid_rst_valid", {31'd0, s_valid}, 32'd0);
      chk("mid_rst_req", {31'd0, s_req}, 32'd0);
      chk("mid_rst_addr", s_addr, RPC);

      // Random traffic against the model.
      gnt_pct = 70;
      rsp_pct = 60;
      lat_max = 4;
      for (int i = 0; i < 4000; i++) begin
         stall_i = ($urandom_range(99) < 30);
         redir_i = ($urandom_range(99) < 4);
         if ($urandom_range(7) == 0) rpc_i = $urandom();
         else rpc_i = $urandom() & 32'hFFFF_FFFC;
         rst_i = ($urandom_range(999) >= 3);
         step();
      end
      rst_i = 1;
      redir_i = 0;
      step();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
